// File: rtl/spi_mem_slave_p_if.sv
// rtl/spi_mem_slave_p_if.sv - SPI pins and memory bus of the SPI memory slave
interface spi_mem_slave_p_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              csb;
  logic              sck;
  logic              si;
  logic              so;
  logic              so_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  csb, sck, si, mem_rdata,
    output so, so_oe, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output csb, sck, si, mem_rdata,
    input  so, so_oe, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/spi_mem_slave_p.sv
// rtl/spi_mem_slave_p.sv - SPI mode-0 slave bridging to a single-port memory bus
module spi_mem_slave_p #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1,
  parameter int REQ_WEL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_mem_slave_p_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE} state_t;

  localparam int MAXW_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAXW    = (MAXW_AD > 8) ? MAXW_AD : 8;
  localparam int CNT_W   = $clog2(MAXW);

  logic [2:0]        sck_s, csb_s;
  logic [1:0]        si_s;
  logic              sck_rise, sck_fall, csb_rise, csb_fall, si_b;
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [MAXW-2:0]   sr;
  logic [DATA_W-1:0] tx_sr, status;
  logic              wel, is_rd, we_pend, inc_pend, rd_cap;

  // Stage [2] of each sck/csb chain is the edge-detect register; si stays aligned with sck stage [1].
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign csb_fall = ~csb_s[1] & csb_s[2];
  assign csb_rise = csb_s[1] & ~csb_s[2];
  assign si_b     = si_s[1];
  assign status   = DATA_W'({wel, 1'b0});

  // Two-flop synchronisers plus edge-detect stage; csb idles high so reset exit creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s <= '0;
      csb_s <= '1;
      si_s  <= '0;
    end else begin
      sck_s <= {sck_s[1:0], bus.sck};
      csb_s <= {csb_s[1:0], bus.csb};
      si_s  <= {si_s[0], bus.si};
    end
  end

  // Frame FSM: command/address/data shifting, memory strobes and the so shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      tx_sr         <= '0;
      wel           <= 1'b0;
      is_rd         <= 1'b0;
      we_pend       <= 1'b0;
      inc_pend      <= 1'b0;
      rd_cap        <= 1'b0;
      bus.so        <= 1'b0;
      bus.so_oe     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.mem_re <= 1'b0;
      rd_cap     <= bus.mem_re;
      we_pend    <= 1'b0;
      inc_pend   <= 1'b0;
      // A completed write beat strobes one clk after mem_wdata loads; the address steps after that.
      if (we_pend && (REQ_WEL == 0 || wel)) begin
        bus.mem_we <= 1'b1;
        inc_pend   <= (AUTO_INC != 0);
      end
      if (inc_pend) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);

      if (csb_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        bus.so    <= 1'b0;
        bus.so_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (csb_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sck_rise) begin
            sr      <= {sr[MAXW-3:0], si_b};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              case ({sr[6:0], si_b})
                8'h02: begin state <= ADDR; is_rd <= 1'b0; end
                8'h03: begin state <= ADDR; is_rd <= 1'b1; end
                8'h05: begin state <= STATUS; tx_sr <= status; end
                8'h06: begin state <= IGNORE; wel <= 1'b1; end
                8'h04: begin state <= IGNORE; wel <= 1'b0; end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            sr      <= {sr[MAXW-3:0], si_b};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              bit_cnt      <= '0;
              bus.mem_addr <= {sr[ADDR_W-2:0], si_b};
              if (is_rd) begin
                bus.mem_re <= 1'b1;
                state      <= RDATA;
              end else begin
                state <= WDATA;
              end
            end
          end
          WDATA: if (sck_rise) begin
            sr      <= {sr[MAXW-3:0], si_b};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt       <= '0;
              bus.mem_wdata <= {sr[DATA_W-2:0], si_b};
              we_pend       <= 1'b1;
            end
          end
          RDATA, STATUS: begin
            if (sck_fall) begin
              bus.so    <= tx_sr[DATA_W-1];
              bus.so_oe <= 1'b1;
              tx_sr     <= {tx_sr[DATA_W-2:0], 1'b0};
            end else if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              // Last bit of a beat was just sampled by the master: fetch the next word.
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt <= '0;
                if (state == STATUS) begin
                  tx_sr <= status;
                end else begin
                  if (AUTO_INC != 0) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                  bus.mem_re <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
      // Read data arrives one clk after mem_re; it lands well before the next sck_fall.
      if (rd_cap) tx_sr <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_spi_mem_slave_p.sv
// tb/tb_spi_mem_slave_p.sv - self-checking bench for spi_mem_slave_p
module tb_spi_mem_slave_p;
  localparam int HALF = 80;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  shadow  [0:65535];
  logic        m_wel = 1'b0;
  ev_t         exp_q [$];
  logic [7:0]  wq [$];
  logic [7:0]  rq [$];
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [15:0] last_we_addr = '0;
  logic [7:0]  last_we_data = '0;
  logic        prev_we = 1'b0;
  logic        prev_re = 1'b0;
  logic        oe_seen = 1'b0;

  always #5 clk = ~clk;

  spi_mem_slave_p_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  spi_mem_slave_p #(.ADDR_W(16), .DATA_W(8), .AUTO_INC(1), .REQ_WEL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory with one-clk read latency.
  always @(posedge clk) begin
    if (bus.mem_we) bus_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= bus_mem[bus.mem_addr];
  end

  // Compare every memory strobe against the next expected event from the model.
  always @(negedge clk) begin : cmp
    ev_t e;
    if (rst_n) begin
      if (bus.so_oe) oe_seen <= 1'b1;
      if (bus.mem_we || bus.mem_re) begin
        chk("strobe_overlap", {31'd0, bus.mem_we & bus.mem_re}, 32'd0);
        chk("strobe_width", {30'd0, prev_we & bus.mem_we, prev_re & bus.mem_re}, 32'd0);
        if (bus.mem_we) begin
          we_cnt       <= we_cnt + 1;
          last_we_addr <= bus.mem_addr;
          last_we_data <= bus.mem_wdata;
        end
        if (bus.mem_re) re_cnt <= re_cnt + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, bus.mem_we}, {31'd0, e.we});
          chk("strobe_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
          if (e.we) chk("strobe_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.data});
        end
      end
      prev_we <= bus.mem_we;
      prev_re <= bus.mem_re;
    end
  end

  task automatic xfer(input logic [15:0] tx, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.si = tx[i];
      #HALF;
      rx[i]   = bus.so;
      bus.sck = 1'b1;
      #HALF;
      bus.sck = 1'b0;
    end
  endtask

  task automatic csb_low();
    @(negedge clk);
    bus.csb = 1'b0;
    #HALF;
  endtask

  task automatic csb_high();
    #HALF;
    bus.csb = 1'b1;
    #(HALF * 2);
  endtask

  task automatic cmd(input logic [7:0] c);
    logic [15:0] rx;
    if (c == 8'h06) m_wel = 1'b1;
    if (c == 8'h04) m_wel = 1'b0;
    csb_low();
    xfer({8'h00, c}, 8, rx);
    csb_high();
  endtask

  task automatic do_write(input logic [15:0] addr);
    logic [15:0] rx;
    ev_t ev;
    for (int i = 0; i < wq.size(); i++) begin
      if (m_wel) begin
        ev.we   = 1'b1;
        ev.addr = addr + 16'(i);
        ev.data = wq[i];
        exp_q.push_back(ev);
        shadow[ev.addr] = wq[i];
      end
    end
    csb_low();
    xfer(16'h0002, 8, rx);
    xfer(addr, 16, rx);
    for (int i = 0; i < wq.size(); i++) xfer({8'h00, wq[i]}, 8, rx);
    csb_high();
    chk("write_drain", exp_q.size(), 32'd0);
  endtask

  // Each beat's last sck_rise prefetches the next word, so n beats give n+1 reads.
  task automatic do_read(input logic [15:0] addr, input int n);
    logic [15:0] rx;
    ev_t ev;
    for (int i = 0; i <= n; i++) begin
      ev.we   = 1'b0;
      ev.addr = addr + 16'(i);
      ev.data = '0;
      exp_q.push_back(ev);
    end
    rq.delete();
    csb_low();
    xfer(16'h0003, 8, rx);
    xfer(addr, 16, rx);
    for (int i = 0; i < n; i++) begin
      xfer(16'h0000, 8, rx);
      rq.push_back(rx[7:0]);
      chk("read_beat", {24'd0, rx[7:0]}, {24'd0, shadow[addr + 16'(i)]});
    end
    chk("so_oe_read", {31'd0, bus.so_oe}, 32'd1);
    csb_high();
    chk("so_oe_idle", {31'd0, bus.so_oe}, 32'd0);
    chk("read_drain", exp_q.size(), 32'd0);
  endtask

  task automatic rdsr(output logic [7:0] st);
    logic [15:0] rx;
    csb_low();
    xfer(16'h0005, 8, rx);
    xfer(16'h0000, 8, rx);
    chk("rdsr", {24'd0, rx[7:0]}, {30'd0, m_wel, 1'b0});
    st = rx[7:0];
    xfer(16'h0000, 8, rx);
    chk("rdsr_repeat", {24'd0, rx[7:0]}, {30'd0, m_wel, 1'b0});
    csb_high();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_so"}, {31'd0, bus.so}, 32'd0);
    chk({tag, "_so_oe"}, {31'd0, bus.so_oe}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_re"}, {31'd0, bus.mem_re}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
  endtask

  initial begin
    logic [15:0] rx;
    logic [7:0]  st;
    int          w0, r0;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'h00;
      shadow[i]  = 8'h00;
    end
    bus.csb = 1'b1;
    bus.sck = 1'b0;
    bus.si  = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // WRITE without WREN is suppressed.
    w0 = we_cnt;
    wq = '{8'h5A};
    do_write(16'h0010);
    chk("no_wel_we_count", we_cnt - w0, 32'd0);

    // WREN then RDSR reports WEL, then the write goes through.
    cmd(8'h06);
    rdsr(st);
    chk("rdsr_after_wren", {24'd0, st}, 32'h02);
    w0 = we_cnt;
    do_write(16'h0010);
    chk("wel_we_count", we_cnt - w0, 32'd1);
    chk("wel_we_addr", {16'd0, last_we_addr}, 32'h0010);

    // WRDI clears WEL.
    cmd(8'h04);
    rdsr(st);
    chk("rdsr_after_wrdi", {24'd0, st}, 32'h00);

    // Reset in the middle of a WRITE data beat.
    cmd(8'h06);
    w0 = we_cnt;
    csb_low();
    xfer(16'h0002, 8, rx);
    xfer(16'h0040, 16, rx);
    xfer(16'h000B, 4, rx);
    @(negedge clk);
    rst_n = 1'b0;
    m_wel = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    bus.csb = 1'b1;
    bus.sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_we_count", we_cnt - w0, 32'd0);

    cmd(8'h06);
    w0 = we_cnt;
    wq = '{8'h56};
    do_write(16'h0003);
    chk("write3_we_count", we_cnt - w0, 32'd1);
    chk("write3_addr", {16'd0, last_we_addr}, 32'h0003);
    chk("write3_data", {24'd0, last_we_data}, 32'h56);

    // Single-beat READ.
    r0 = re_cnt;
    do_read(16'h0003, 1);
    chk("read3_value", {24'd0, rq[0]}, 32'h56);
    chk("read3_re_count", re_cnt - r0, 32'd2);

    // Burst WRITE / READ across a byte boundary.
    w0 = we_cnt;
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(16'h00FF);
    chk("burst_we_count", we_cnt - w0, 32'd3);
    chk("burst_last_addr", {16'd0, last_we_addr}, 32'h0101);
    do_read(16'h00FF, 3);
    chk("burst_rd0", {24'd0, rq[0]}, 32'h11);
    chk("burst_rd1", {24'd0, rq[1]}, 32'h22);
    chk("burst_rd2", {24'd0, rq[2]}, 32'h33);

    // Address wrap from all-ones to zero.
    wq = '{8'hAA, 8'hBB};
    do_write(16'hFFFF);
    chk("wrap_last_addr", {16'd0, last_we_addr}, 32'h0000);
    do_read(16'hFFFF, 2);
    chk("wrap_rd0", {24'd0, rq[0]}, 32'hAA);
    chk("wrap_rd1", {24'd0, rq[1]}, 32'hBB);

    // Abort after 5 of 8 data bits, then a fresh frame still works.
    w0 = we_cnt;
    csb_low();
    xfer(16'h0002, 8, rx);
    xfer(16'h0030, 16, rx);
    xfer(16'h0015, 5, rx);
    csb_high();
    repeat (4) @(negedge clk);
    chk("abort_we_count", we_cnt - w0, 32'd0);
    rdsr(st);
    chk("rdsr_after_abort", {24'd0, st}, 32'h02);

    // Unknown command: no strobes, so_oe stays low.
    w0 = we_cnt;
    r0 = re_cnt;
    oe_seen = 1'b0;
    csb_low();
    xfer(16'h00FF, 8, rx);
    xfer(16'hABCD, 16, rx);
    csb_high();
    chk("unknown_oe", {31'd0, oe_seen}, 32'd0);
    chk("unknown_strobes", (we_cnt - w0) + (re_cnt - r0), 32'd0);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_mem_slave_p.md
Name: spi_mem_slave_p

Overview:
Parametrised SPI (mode 0) slave that bridges an external SPI master to a synchronous single-port memory bus. It is the next generation of the lab SPI slave, which used fixed 16-bit addresses and 8-bit data. This block adds:
- configurable address and data widths
- burst auto-increment
- a write-enable latch and a status-register read
- an explicit so output enable

It runs entirely in the system clock domain. sck, csb and si are oversampled through synchronisers.

Parameters:
ADDR_W, 16, address width in bits; address phase is ADDR_W sck bits, MSB first
DATA_W, 8, data beat width in bits, MSB first
AUTO_INC, 1, 1 = address increments per beat within one csb frame; 0 = address fixed for the frame
REQ_WEL, 0, 1 = WRITE beats are suppressed unless the write-enable latch is set

Ports:
clk  in  1  system clock; must be at least 8x the sck frequency
rst_n  in  1  asynchronous active-low reset
csb  in  1  SPI chip select, active low, asynchronous to clk
sck  in  1  SPI clock, asynchronous to clk
si  in  1  SPI serial data in
so  out  1  SPI serial data out
so_oe  out  1  so drive enable; 1 only during the READ/RDSR data phase
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  one-clk write strobe
mem_re  out  1  one-clk read strobe
mem_rdata  in  DATA_W  read data; valid exactly 1 clk after mem_re

Behaviour:
- Reset (async, rst_n=0): so=0, so_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, WEL=0, state=IDLE, all shift registers and counters cleared. Asserting reset mid-frame aborts the frame with no memory access.
- Synchronisers: 2-FF on sck, csb, si, followed by an edge-detect register.
  - sck_rise: sample si.
  - sck_fall: shift so.
  - csb_fall: start frame.
  - csb_rise: abort to IDLE.
- csb_rise has priority over any sck edge detected in the same clk. A partially shifted byte or beat is discarded; no mem_we is issued for it.
- Commands (8 bits, MSB first), decoded on the 8th sck_rise:
  - 0x02 WRITE → ADDR
  - 0x03 READ → ADDR
  - 0x05 RDSR → STATUS
  - 0x06 WREN: set WEL → IGNORE
  - 0x04 WRDI: clear WEL → IGNORE
  - any other value → IGNORE
- States: IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE.
  - IDLE → CMD on csb_fall.
  - IGNORE holds until csb_rise.
- ADDR: shift ADDR_W bits. On the last bit:
  - load mem_addr
  - WRITE → WDATA
  - READ → pulse mem_re the same clk, capture mem_rdata 1 clk later into the tx shifter, → RDATA
- WDATA: after each DATA_W bits:
  - mem_wdata <= beat, then mem_we pulses 1 clk later with the current mem_addr.
  - Pulse is suppressed if REQ_WEL=1 and WEL=0.
  - If AUTO_INC, mem_addr increments in the clk after the strobe.
  - WEL is not auto-cleared.
- RDATA: tx MSB appears on so at the first sck_fall after the address; one bit per sck_fall thereafter.
  - On the DATA_W-th sck_rise of a beat, if AUTO_INC: increment mem_addr, pulse mem_re, reload the tx shifter from mem_rdata before the next sck_fall.
  - If AUTO_INC=0, re-read the same address.
- STATUS: tx shifter loaded with status word, zero-extended to DATA_W: bit1=WEL, bit0=0 (never busy), other bits 0. The word repeats every DATA_W bits until csb_rise.
- so_oe=1 from the cycle the first tx bit is driven until csb_rise; otherwise so=0 and so_oe=0.
- Address arithmetic: modulo 2^ADDR_W; all-ones wraps to 0.
- mem_we and mem_re are never asserted in the same clk; each is exactly 1 clk wide.

Test Plan:
- Reset mid-WRITE data phase → all outputs at reset values, no mem_we. A following normal WRITE of 0x0003←0x56 succeeds: one mem_we, mem_addr=0x0003, mem_wdata=0x56.
- WRITE 0x0003←0x56 then READ 0x0003 (memory model, 1-clk rdata) → so shifts 0x56 MSB first; exactly one mem_re for the first beat.
- Burst WRITE at 0x00FF with 0x11,0x22,0x33 (AUTO_INC=1) → mem_we at 0x00FF, 0x0100, 0x0101. Burst READ of 3 beats from 0x00FF returns 0x11, 0x22, 0x33.
- ADDR_W=16 wrap: burst WRITE 0xAA,0xBB at 0xFFFF → writes at 0xFFFF then 0x0000.
- REQ_WEL=1:
  - WRITE 0x0010←0x5A without WREN → no mem_we.
  - WREN, then RDSR → so returns 0x02.
  - WRITE → mem_we occurs.
  - WRDI, then RDSR → 0x00.
- Abort: csb rises after 5 of 8 data bits → no mem_we, state IDLE. Unknown command 0xFF → no memory strobes, so_oe stays 0.
